// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: MMIO page, register offsets,
// STATUS bit positions and reset values.
package dmem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LED_W  = 8;
    localparam int unsigned STAT_W = 2;

    localparam logic [15:0] MMIO_PAGE  = 16'hFFFF;
    localparam logic [15:0] OFF_CYCLES = 16'h0000;
    localparam logic [15:0] OFF_BTN    = 16'h0004;
    localparam logic [15:0] OFF_LED    = 16'h0008;
    localparam logic [15:0] OFF_TCMP   = 16'h000C;
    localparam logic [15:0] OFF_STATUS = 16'h0010;

    localparam int unsigned STAT_HIT      = 0;
    localparam int unsigned STAT_MISALIGN = 1;

    localparam logic [DATA_W-1:0] TCMP_RST = 32'hFFFF_FFFF;

    // Upper half of the byte address selects the peripheral page.
    function automatic logic is_mmio(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:16] == MMIO_PAGE;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store port between the single-cycle datapath and the data-memory responder.
interface data_mem_responder_if;
    import dmem_pkg::*;

    logic              memwrite;
    logic              memread;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (
        output memwrite, memread, addr, writedata,
        input  readdata
    );

    modport slave (
        input  memwrite, memread, addr, writedata,
        output readdata
    );

endinterface

// File: rtl/data_mem_responder_btn_edge_sync.sv
// Two-flop synchronizer per button followed by a previous-value flop; emits a
// one-cycle rising-edge pulse on the synchronized level.
module btn_edge_sync #(
    parameter int unsigned N_BTN = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] buttons,
    output logic [N_BTN-1:0] rise_c
);

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;
    logic [N_BTN-1:0] prev;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= buttons;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise_c = sync2 & ~prev;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM with combinational read plus a peripheral page
// (cycle counter, compare timer, button edge latches, LEDs, status).
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned RAM_WORDS = 256,
    parameter int unsigned N_BTN     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus,
    input  logic [N_BTN-1:0]     buttons,
    output logic [LED_W-1:0]     led,
    output logic                 irq
);

    localparam int unsigned IDX_W = $clog2(RAM_WORDS);

    logic [DATA_W-1:0] ram [RAM_WORDS];

    logic [DATA_W-1:0] cycles;
    logic [DATA_W-1:0] tcmp;
    logic [N_BTN-1:0]  btn;
    logic [LED_W-1:0]  led_q;
    logic [STAT_W-1:0] status;

    logic              mmio_c;
    logic              misalign_c;
    logic              store_c;
    logic              load_c;
    logic [15:0]       offset_c;
    logic [IDX_W-1:0]  ram_idx_c;
    logic [N_BTN-1:0]  rise_c;
    logic [N_BTN-1:0]  btn_clr_c;
    logic [STAT_W-1:0] status_set_c;
    logic [STAT_W-1:0] status_clr_c;
    logic [DATA_W-1:0] readdata_c;

    btn_edge_sync #(.N_BTN(N_BTN)) u_btn_edge_sync (
        .clk     (clk),
        .reset   (reset),
        .buttons (buttons),
        .rise_c  (rise_c)
    );

    // Access decode; a simultaneous read and write is a plain store.
    always_comb begin
        mmio_c     = is_mmio(bus.addr);
        offset_c   = bus.addr[15:0];
        ram_idx_c  = bus.addr[IDX_W+1:2];
        misalign_c = (bus.addr[1:0] != 2'b00) && (bus.memread || bus.memwrite);
        store_c    = bus.memwrite && !misalign_c;
        load_c     = bus.memread && !bus.memwrite && !misalign_c;
    end

    // Side-effect masks: clear-on-read of BTN and write-1-to-clear of STATUS.
    always_comb begin
        btn_clr_c    = '0;
        status_clr_c = '0;
        status_set_c = '0;
        if (load_c && mmio_c && offset_c == OFF_BTN) begin
            btn_clr_c = btn;
        end
        if (store_c && mmio_c && offset_c == OFF_STATUS) begin
            status_clr_c = bus.writedata[STAT_W-1:0];
        end
        status_set_c[STAT_HIT]      = (cycles == tcmp);
        status_set_c[STAT_MISALIGN] = misalign_c;
    end

    // Combinational load data.
    always_comb begin
        readdata_c = '0;
        if (!misalign_c) begin
            if (mmio_c) begin
                case (offset_c)
                    OFF_CYCLES: readdata_c = cycles;
                    OFF_BTN:    readdata_c = DATA_W'(btn);
                    OFF_LED:    readdata_c = DATA_W'(led_q);
                    OFF_TCMP:   readdata_c = tcmp;
                    OFF_STATUS: readdata_c = DATA_W'(status);
                    default:    readdata_c = '0;
                endcase
            end else begin
                readdata_c = ram[ram_idx_c];
            end
        end
    end

    assign bus.readdata = readdata_c;

    // RAM contents survive reset; only the write strobe is gated by it.
    always_ff @(posedge clk) begin
        if (reset && store_c && !mmio_c) begin
            ram[ram_idx_c] <= bus.writedata;
        end
    end

    // Peripheral registers; in every register a set in the same cycle beats a clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cycles <= '0;
            tcmp   <= TCMP_RST;
            btn    <= '0;
            led_q  <= '0;
            status <= '0;
        end else begin
            cycles <= cycles + DATA_W'(1);
            btn    <= (btn & ~btn_clr_c) | rise_c;
            status <= (status & ~status_clr_c) | status_set_c;
            if (store_c && mmio_c && offset_c == OFF_LED) begin
                led_q <= bus.writedata[LED_W-1:0];
            end
            if (store_c && mmio_c && offset_c == OFF_TCMP) begin
                tcmp <= bus.writedata;
            end
        end
    end

    assign led = led_q;
    assign irq = status[STAT_HIT];

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with a behavioural reference model and
// per-cycle comparison of led, irq and load data.
module tb_data_mem_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] buttons;
    logic [7:0] led;
    logic       irq;

    data_mem_responder_if bus();

    data_mem_responder #(.RAM_WORDS(256), .N_BTN(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .buttons (buttons),
        .led     (led),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [31:0] m_ram [256];
    bit          m_ram_v [256];
    logic [31:0] m_cyc;
    logic [31:0] m_tcmp;
    logic [3:0]  m_btn;
    logic [7:0]  m_led;
    logic [1:0]  m_status;
    logic [3:0]  m_hist [$];
    bit          model_ok = 1'b0;

    // Hand-computed literal expectation for the load in flight.
    bit          lit_valid = 1'b0;
    logic [31:0] lit_exp   = '0;
    string       lit_name  = "";

    // Model: each button sample taken at an edge produces its latch bit two edges later.
    always @(posedge clk) begin
        logic [31:0] a;
        logic        mis, mm, st, ld, hit;
        logic [15:0] off;
        logic [3:0]  rise;
        if (!reset) begin
            m_cyc    = '0;
            m_tcmp   = 32'hFFFF_FFFF;
            m_btn    = '0;
            m_led    = '0;
            m_status = '0;
            m_hist.delete();
            repeat (3) m_hist.push_back(4'h0);
            model_ok = 1'b1;
        end else begin
            a    = bus.addr;
            off  = a[15:0];
            mm   = (a[31:16] == 16'hFFFF);
            mis  = (bus.memread || bus.memwrite) && (a[1:0] != 2'b00);
            st   = bus.memwrite && !mis;
            ld   = bus.memread && !bus.memwrite && !mis;
            hit  = (m_cyc == m_tcmp);
            rise = m_hist[m_hist.size()-2] & ~m_hist[m_hist.size()-3];
            if (st && !mm) begin
                m_ram[a[9:2]]   = bus.writedata;
                m_ram_v[a[9:2]] = 1'b1;
            end
            if (ld && mm && off == 16'h0004) m_btn = 4'h0;
            m_btn = m_btn | rise;
            if (st && mm && off == 16'h0008) m_led = bus.writedata[7:0];
            if (st && mm && off == 16'h000C) m_tcmp = bus.writedata;
            if (st && mm && off == 16'h0010) m_status = m_status & ~bus.writedata[1:0];
            m_status = m_status | {mis, hit};
            m_cyc = m_cyc + 32'd1;
            m_hist.push_back(buttons);
        end
    end

    // Compare process: outputs are settled at the falling edge.
    always @(negedge clk) begin
        logic [31:0] exp;
        bit          known;
        if (model_ok) begin
            total++;
            if (led !== m_led) begin
                bad++;
                $display("FAIL led: got %h want %h at %0t", led, m_led, $time);
            end
            total++;
            if (irq !== m_status[0]) begin
                bad++;
                $display("FAIL irq: got %b want %b at %0t", irq, m_status[0], $time);
            end
            if (bus.memread) begin
                known = 1'b1;
                exp   = '0;
                if (bus.addr[1:0] != 2'b00) begin
                    exp = '0;
                end else if (bus.addr[31:16] == 16'hFFFF) begin
                    case (bus.addr[15:0])
                        16'h0000: exp = m_cyc;
                        16'h0004: exp = {28'h0, m_btn};
                        16'h0008: exp = {24'h0, m_led};
                        16'h000C: exp = m_tcmp;
                        16'h0010: exp = {30'h0, m_status};
                        default:  exp = '0;
                    endcase
                end else begin
                    known = m_ram_v[bus.addr[9:2]];
                    exp   = m_ram[bus.addr[9:2]];
                end
                if (known) begin
                    total++;
                    if (bus.readdata !== exp) begin
                        bad++;
                        $display("FAIL model_rd @%h: got %h want %h at %0t",
                                 bus.addr, bus.readdata, exp, $time);
                    end
                end
            end
            if (lit_valid) begin
                total++;
                if (bus.readdata !== lit_exp) begin
                    bad++;
                    $display("FAIL %s: got %h want %h at %0t",
                             lit_name, bus.readdata, lit_exp, $time);
                end
            end
        end
    end

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd);
        bus.memread   = rd;
        bus.memwrite  = wr;
        bus.addr      = a;
        bus.writedata = wd;
        @(posedge clk);
        #1;
        bus.memread  = 1'b0;
        bus.memwrite = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic chk(input logic [31:0] a, input logic [31:0] exp, input string nm);
        lit_exp   = exp;
        lit_name  = nm;
        lit_valid = 1'b1;
        drive(1'b1, 1'b0, a, 32'h0);
        lit_valid = 1'b0;
    endtask

    initial begin
        reset         = 1'b0;
        buttons       = 4'h0;
        bus.memread   = 1'b0;
        bus.memwrite  = 1'b0;
        bus.addr      = '0;
        bus.writedata = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // Reset values and counter start.
        chk(32'hFFFF_0000, 32'd0, "cyc0");
        chk(32'hFFFF_0000, 32'd1, "cyc1");
        chk(32'hFFFF_000C, 32'hFFFF_FFFF, "tcmp_rst");
        chk(32'hFFFF_0010, 32'h0, "status_rst");
        chk(32'hFFFF_0008, 32'h0, "led_rst");

        // RAM store, load and aliasing.
        drive(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        chk(32'h0000_0010, 32'hDEAD_BEEF, "ram_rd");
        chk(32'h0000_0410, 32'hDEAD_BEEF, "ram_alias");
        drive(1'b0, 1'b1, 32'h0000_0020, 32'h1111_1111);

        // Misaligned access.
        drive(1'b0, 1'b1, 32'h0000_0013, 32'h1234_5678);
        chk(32'h0000_0010, 32'hDEAD_BEEF, "mis_keep");
        chk(32'h0000_0013, 32'h0, "mis_rd");
        chk(32'hFFFF_0010, 32'h2, "mis_status");
        drive(1'b0, 1'b1, 32'hFFFF_0010, 32'h2);
        chk(32'hFFFF_0010, 32'h0, "status_w1c");

        // LED, read-only and unmapped offsets.
        drive(1'b0, 1'b1, 32'hFFFF_0008, 32'h0000_01A5);
        chk(32'hFFFF_0008, 32'hA5, "led_rd");
        drive(1'b0, 1'b1, 32'hFFFF_0000, 32'h55);
        drive(1'b0, 1'b1, 32'hFFFF_0020, 32'h77);
        chk(32'hFFFF_0020, 32'h0, "unmapped");
        chk(32'hFFFF_0008, 32'hA5, "led_after_ro");
        chk(32'hFFFF_0004, 32'h0, "btn_idle");

        // Button 2 rises; latched two edges after capture.
        buttons = 4'h4;
        idle(2);
        chk(32'hFFFF_0004, 32'h0, "btn_early");
        chk(32'hFFFF_0004, 32'h4, "btn_set");
        chk(32'hFFFF_0004, 32'h0, "btn_cleared");
        idle(3);
        chk(32'hFFFF_0004, 32'h0, "btn_held");

        // Clear-on-read clears only returned bits; a new edge in that cycle survives.
        buttons = 4'h0;
        idle(4);
        buttons = 4'h1;
        idle(3);
        buttons = 4'h5;
        idle(2);
        chk(32'hFFFF_0004, 32'h1, "btn_rd_b0");
        chk(32'hFFFF_0004, 32'h4, "btn_b2_kept");
        chk(32'hFFFF_0004, 32'h0, "btn_b2_clr");

        // Same bit re-triggers on the clearing edge: set wins.
        buttons = 4'h1;
        idle(3);
        buttons = 4'h5;
        idle(1);
        buttons = 4'h1;
        idle(1);
        buttons = 4'h5;
        idle(2);
        chk(32'hFFFF_0004, 32'h4, "btn_setwin_rd");
        chk(32'hFFFF_0004, 32'h4, "btn_setwin_kept");
        chk(32'hFFFF_0004, 32'h0, "btn_setwin_clr");

        // Timer compare after a fresh reset.
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
        drive(1'b0, 1'b1, 32'hFFFF_000C, 32'd20);
        idle(18);
        chk(32'hFFFF_0000, 32'd19, "cyc19");
        chk(32'hFFFF_0000, 32'd20, "cyc20");
        chk(32'hFFFF_0010, 32'h1, "timer_hit");
        drive(1'b0, 1'b1, 32'hFFFF_0010, 32'h1);
        chk(32'hFFFF_0010, 32'h0, "timer_w1c");

        // Build STATUS=3, LED=A5, then reset with a store in flight.
        drive(1'b0, 1'b1, 32'hFFFF_000C, 32'd26);
        drive(1'b0, 1'b1, 32'hFFFF_0008, 32'hA5);
        drive(1'b1, 1'b0, 32'h0000_0021, 32'h0);
        chk(32'hFFFF_0010, 32'h3, "status3");
        chk(32'h0000_0010, 32'hDEAD_BEEF, "ram_keep_rst");
        reset = 1'b0;
        drive(1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D);
        reset = 1'b1;
        chk(32'hFFFF_0000, 32'd0, "cyc_restart");
        chk(32'hFFFF_0008, 32'h0, "led_cleared");
        chk(32'hFFFF_0010, 32'h0, "status_cleared");
        chk(32'hFFFF_000C, 32'hFFFF_FFFF, "tcmp_reset");
        chk(32'h0000_0020, 32'h1111_1111, "rst_store_drop");
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
